// File: rtl/jtopl_pkg.sv
// Shared constants, state type and slot arithmetic for the operator write scheduler.
package jtopl_pkg;

  localparam int SLOT_N = 18;

  localparam logic [1:0] BANK_AM_MUL = 2'd0;
  localparam logic [1:0] BANK_KSL_TL = 2'd1;
  localparam logic [1:0] BANK_AR_DR  = 2'd2;
  localparam logic [1:0] BANK_SL_RR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } wrsched_st_t;

  // Returned need vector: bit0 = stage I, bit1 = stage II, bit2 = stage IV.
  function automatic logic [2:0] stage_need(input logic [1:0] bank);
    logic [2:0] need;
    case (bank)
      BANK_AM_MUL, BANK_KSL_TL: need = 3'b110;
      default:                  need = 3'b001;
    endcase
    return need;
  endfunction

  function automatic logic [4:0] add_mod18(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(SLOT_N)) s = s - 6'(SLOT_N);
    return s[4:0];
  endfunction

endpackage

// File: rtl/jtopl_wrsched_if.sv
// CPU-side write port of the operator write scheduler.
interface jtopl_wrsched_if;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       ovf;

  modport master (output wr, addr, din, input busy, done, ovf);
  modport slave  (input wr, addr, din, output busy, done, ovf);
endinterface

// File: rtl/jtopl_wrsched_dec.sv
// Operator register address decoder: page 0x20..0x80 plus offset -> bank and slot.
module jtopl_wrsched_dec
  import jtopl_pkg::*;
(
  input  logic [7:0] addr,
  output logic       valid,
  output logic [1:0] bank,
  output logic [4:0] tgt
);

  logic [2:0] page;
  logic [4:0] off;
  logic [1:0] grp;
  logic [2:0] sub;

  always_comb begin
    page  = addr[7:5];
    off   = addr[4:0];
    grp   = off[4:3];
    sub   = off[2:0];
    valid = (page >= 3'd1) && (page <= 3'd4) && (off <= 5'h15) && (sub <= 3'd5);
    bank  = 2'(page - 3'd1);
    // Offsets 0-2 of each group hit modulator slots, 3-5 hit the carrier half.
    if (sub < 3'd3) tgt = 5'(grp) * 5'd3 + 5'(sub);
    else            tgt = 5'd9 + 5'(grp) * 5'd3 + 5'(sub) - 5'd3;
  end

endmodule

// File: rtl/jtopl_wrsched.sv
// Operator write scheduler: master slot counter plus per-stage capture strobes.
// Define JTOPL_WRFIFO_EN to queue up to two writes that arrive while busy.
//
// state   | meaning
// IDLE    | no write in flight, accepts a new write (or FIFO head)
// WAIT    | bank select high, waiting for each needed stage slot
// DONE    | one-clk done pulse, drops busy and bank select
module jtopl_wrsched
  import jtopl_pkg::*;
#(
  parameter int SLOTS   = 18,
  parameter int OFFS_I  = 0,
  parameter int OFFS_II = 1,
  parameter int OFFS_IV = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  jtopl_wrsched_if.slave  cpu,
  output logic [7:0]      dout,
  output logic [4:0]      slot,
  output logic            up_am_mul,
  output logic            up_ksl_tl,
  output logic            up_ar_dr,
  output logic            up_sl_rr,
  output logic            update_op_I,
  output logic            update_op_II,
  output logic            update_op_IV
);

  localparam logic [4:0] OI   = 5'(OFFS_I);
  localparam logic [4:0] OII  = 5'(OFFS_II);
  localparam logic [4:0] OIV  = 5'(OFFS_IV);
  localparam logic [4:0] LAST = 5'(SLOTS - 1);

  wrsched_st_t st, st_nx;
  logic        dec_vld, wr_ok, lost, q_busy;
  logic [1:0]  dec_bank;
  logic [4:0]  dec_tgt;
  logic        src_vld;
  logic [1:0]  src_bank;
  logic [4:0]  src_tgt;
  logic [7:0]  src_data;
  logic [4:0]  tgt_r, tgt_nx;
  logic [7:0]  dout_nx;
  logic [2:0]  need, need_nx, upd;
  logic [3:0]  sel, sel_nx;
  logic        busy_r, busy_nx, ovf_r, ovf_nx;
  logic        hit_i, hit_ii, hit_iv;

  jtopl_wrsched_dec u_dec (
    .addr  (cpu.addr),
    .valid (dec_vld),
    .bank  (dec_bank),
    .tgt   (dec_tgt)
  );

  assign wr_ok = cpu.wr & dec_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   slot <= '0;
    else if (cen) slot <= (slot == LAST) ? 5'd0 : slot + 5'd1;
  end

`ifdef JTOPL_WRFIFO_EN
  logic [14:0] fifo_mem [2];
  logic        rd_ptr, wr_ptr, push, pop;
  logic [1:0]  fifo_cnt, cnt_nx;

  always_comb begin
    pop     = (st == ST_IDLE) && (fifo_cnt != 2'd0);
    push    = wr_ok && ((st != ST_IDLE) || (fifo_cnt != 2'd0)) && (fifo_cnt != 2'd2);
    lost    = wr_ok && ((st != ST_IDLE) || (fifo_cnt != 2'd0)) && (fifo_cnt == 2'd2);
    src_vld = pop || (wr_ok && (st == ST_IDLE));
    {src_tgt, src_bank, src_data} = pop ? fifo_mem[rd_ptr] : {dec_tgt, dec_bank, cpu.din};
    cnt_nx  = fifo_cnt + {1'b0, push} - {1'b0, pop};
    q_busy  = (cnt_nx != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {dec_tgt, dec_bank, cpu.din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= cnt_nx;
    end
  end
`else
  always_comb begin
    src_vld  = wr_ok && (st == ST_IDLE);
    lost     = wr_ok && (st != ST_IDLE);
    src_tgt  = dec_tgt;
    src_bank = dec_bank;
    src_data = cpu.din;
    q_busy   = 1'b0;
  end
`endif

  assign hit_i  = (slot == add_mod18(tgt_r, OI));
  assign hit_ii = (slot == add_mod18(tgt_r, OII));
  assign hit_iv = (slot == add_mod18(tgt_r, OIV));

  always_comb begin
    upd     = (st == ST_WAIT) ? (need & {hit_iv, hit_ii, hit_i}) : 3'b000;
    st_nx   = st;
    need_nx = need;
    tgt_nx  = tgt_r;
    dout_nx = dout;
    sel_nx  = sel;
    ovf_nx  = ovf_r | lost;
    case (st)
      ST_IDLE: begin
        if (src_vld) begin
          st_nx   = ST_WAIT;
          tgt_nx  = src_tgt;
          dout_nx = src_data;
          need_nx = stage_need(src_bank);
          sel_nx  = 4'b0001 << src_bank;
        end
      end
      ST_WAIT: begin
        // A strobe is only consumed on an enabled edge.
        if (cen) begin
          need_nx = need & ~upd;
          if (need_nx == 3'b000) st_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        st_nx  = ST_IDLE;
        sel_nx = 4'b0000;
      end
      default: st_nx = ST_IDLE;
    endcase
    busy_nx = (st_nx != ST_IDLE) || q_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= ST_IDLE;
      need   <= 3'b000;
      tgt_r  <= '0;
      dout   <= '0;
      sel    <= '0;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      st     <= st_nx;
      need   <= need_nx;
      tgt_r  <= tgt_nx;
      dout   <= dout_nx;
      sel    <= sel_nx;
      busy_r <= busy_nx;
      ovf_r  <= ovf_nx;
    end
  end

  assign cpu.busy     = busy_r;
  assign cpu.done     = (st == ST_DONE);
  assign cpu.ovf      = ovf_r;
  assign up_am_mul    = sel[0];
  assign up_ksl_tl    = sel[1];
  assign up_ar_dr     = sel[2];
  assign up_sl_rr     = sel[3];
  assign update_op_I  = upd[0];
  assign update_op_II = upd[1];
  assign update_op_IV = upd[2];

endmodule

// File: tb/tb_jtopl_wrsched.sv
// Self-checking bench for jtopl_wrsched: directed scenarios plus randomized traffic
// against a transaction-level model of the scheduler.
module tb_jtopl_wrsched;

  localparam int OFFS_I  = 0;
  localparam int OFFS_II = 1;
  localparam int OFFS_IV = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen = 1'b1;
  logic [7:0] dout;
  logic [4:0] slot;
  logic       up_am_mul, up_ksl_tl, up_ar_dr, up_sl_rr;
  logic       update_op_I, update_op_II, update_op_IV;

  jtopl_wrsched_if cpu_if ();

  jtopl_wrsched #(.SLOTS(18), .OFFS_I(OFFS_I), .OFFS_II(OFFS_II), .OFFS_IV(OFFS_IV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .cpu          (cpu_if),
    .dout         (dout),
    .slot         (slot),
    .up_am_mul    (up_am_mul),
    .up_ksl_tl    (up_ksl_tl),
    .up_ar_dr     (up_ar_dr),
    .up_sl_rr     (up_sl_rr),
    .update_op_I  (update_op_I),
    .update_op_II (update_op_II),
    .update_op_IV (update_op_IV)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [4:0] tgt;
    logic [1:0] bank;
    logic [7:0] data;
  } wr_t;

  wr_t        fq[$];
  int         m_slot = 0;
  int         m_phase = 0;     // 0 idle, 1 waiting for stages, 2 finishing
  bit         m_need[3];       // stage I, II, IV still outstanding
  int         m_tgt = 0;
  int         m_bank = 0;
  logic [7:0] m_dout = 8'h00;
  bit         m_busy = 1'b0;
  bit         m_ovf = 1'b0;

  function automatic bit m_valid(input logic [7:0] a);
    int hi, off;
    hi  = int'(a[7:5]);
    off = int'(a[4:0]);
    return (hi >= 1) && (hi <= 4) && (off <= 21) && ((off % 8) <= 5);
  endfunction

  function automatic wr_t mk(input logic [7:0] a, input logic [7:0] d);
    wr_t r;
    int off, grp, sub, t;
    off = int'(a[4:0]);
    grp = off / 8;
    sub = off % 8;
    t   = (sub < 3) ? grp * 3 + sub : 9 + grp * 3 + (sub - 3);
    r.tgt  = 5'(t);
    r.bank = 2'(int'(a[7:5]) - 1);
    r.data = d;
    return r;
  endfunction

  function automatic bit stage_hit(input int k);
    int off;
    off = (k == 0) ? OFFS_I : (k == 1) ? OFFS_II : OFFS_IV;
    return (m_phase == 1) && m_need[k] && (m_slot == (m_tgt + off) % 18);
  endfunction

  task automatic m_load(input wr_t w);
    m_phase = 1;
    m_tgt   = int'(w.tgt);
    m_bank  = int'(w.bank);
    m_dout  = w.data;
    m_need[0] = (m_bank >= 2);
    m_need[1] = (m_bank < 2);
    m_need[2] = (m_bank < 2);
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit hit[3];
    bit wv, took;
    int pre_q;
    if (!rst_n) begin
      m_slot = 0; m_phase = 0; m_tgt = 0; m_bank = 0; m_dout = 8'h00;
      m_busy = 0; m_ovf = 0;
      for (int k = 0; k < 3; k++) m_need[k] = 0;
      fq.delete();
    end else begin
      for (int k = 0; k < 3; k++) hit[k] = stage_hit(k);
      wv    = cpu_if.wr && m_valid(cpu_if.addr);
      took  = 0;
      pre_q = fq.size();
      case (m_phase)
        0: begin
          if (fq.size() > 0) m_load(fq.pop_front());
          else if (wv) begin m_load(mk(cpu_if.addr, cpu_if.din)); took = 1; end
        end
        1: begin
          if (cen) begin
            for (int k = 0; k < 3; k++) if (hit[k]) m_need[k] = 0;
            if (!(m_need[0] || m_need[1] || m_need[2])) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
      if (wv && !took) begin
`ifdef JTOPL_WRFIFO_EN
        if (pre_q < 2) fq.push_back(mk(cpu_if.addr, cpu_if.din));
        else m_ovf = 1;
`else
        m_ovf = 1;
`endif
      end
      m_busy = (m_phase != 0) || (fq.size() != 0);
      if (cen) m_slot = (m_slot + 1) % 18;
    end
  end

  function automatic int exp_flags();
    bit [3:0] sel;
    sel = (m_phase != 0) ? (4'b0001 << m_bank) : 4'b0000;
    return int'({m_busy, m_phase == 2, m_ovf, sel[0], sel[1], sel[2], sel[3],
                 stage_hit(0), stage_hit(1), stage_hit(2)});
  endfunction

  // ---------------- per-cycle comparison against the model ----------------
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("slot", int'(slot), m_slot);
      chk("dout", int'(dout), int'(m_dout));
      chk("flags{busy,done,ovf,sel,upd}",
          int'({cpu_if.busy, cpu_if.done, cpu_if.ovf, up_am_mul, up_ksl_tl, up_ar_dr, up_sl_rr,
                update_op_I, update_op_II, update_op_IV}), exp_flags());
    end
  end

  // ---------------- cen pattern and monitors ----------------
  int cen_mode = 0;
  int cen_cnt = 0;
  always @(negedge clk) begin
    #1;
    cen_cnt++;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cen_cnt % 4 == 0);
      default: cen = 1'($urandom_range(0, 1));
    endcase
  end

  int         done_cnt = 0;
  logic [7:0] done_seq[$];
  int         held_i = 0, cap_i = 0, cap_slot = -1;
  always @(negedge clk) begin
    if (cpu_if.done) begin done_cnt++; done_seq.push_back(dout); end
    if (update_op_I) held_i++;
    if (update_op_I && cen) begin cap_i++; cap_slot = int'(slot); end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    cpu_if.wr = 1'b1; cpu_if.addr = a; cpu_if.din = d;
    step();
    cpu_if.wr = 1'b0;
  endtask

  function automatic bit sig(input int w, input int v);
    case (w)
      0:       return update_op_I;
      1:       return update_op_II;
      2:       return update_op_IV;
      3:       return cpu_if.done;
      default: return int'(slot) == v;
    endcase
  endfunction

  task automatic wait_for(input int w, input int v, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = sig(w, v);
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  logic [7:0] ra;

  initial begin
    rst_n = 1'b1;
    cpu_if.wr = 1'b0; cpu_if.addr = 8'h00; cpu_if.din = 8'h00;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    chk("rst_busy", int'(cpu_if.busy), 0);
    chk("rst_slot", int'(slot), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // bank 0x40, tgt 9: II at slot 10, IV at slot 12
    do_write(8'h43, 8'h2A);
    wait_for(1, 0, "ii_0x43");
    chk("ii_slot_0x43", int'(slot), 10);
    chk("ksl_tl_sel", int'(up_ksl_tl), 1);
    chk("dout_0x43", int'(dout), 8'h2A);
    wait_for(2, 0, "iv_0x43");
    chk("iv_slot_0x43", int'(slot), 12);
    wait_for(3, 0, "done_0x43");
    step();
    chk("busy_after_done", int'(cpu_if.busy), 0);

    // wraparound, tgt 17
    do_write(8'h35, 8'h77);
    wait_for(1, 0, "ii_wrap");
    chk("ii_slot_wrap", int'(slot), 0);
    chk("am_mul_sel", int'(up_am_mul), 1);
    wait_for(2, 0, "iv_wrap");
    chk("iv_slot_wrap", int'(slot), 2);
    wait_for(3, 0, "done_wrap");
    step();

    // cen every 4th clk, bank 0x80 to slot 0
    cen_mode = 1;
    wait_for(4, 5, "slot5_a");
    held_i = 0; cap_i = 0;
    do_write(8'h80, 8'h5C);
    wait_for(3, 0, "done_cen");
    chk("cen_captures", cap_i, 1);
    chk("cen_held_clks", held_i, 4);
    chk("cen_cap_slot", cap_slot, 0);
    chk("cen_dout", int'(dout), 8'h5C);
    cen_mode = 0;
    repeat (2) step();

    // invalid addresses
    do_write(8'h26, 8'h11);
    do_write(8'hA0, 8'h22);
    repeat (3) step();
    chk("inv_busy", int'(cpu_if.busy), 0);
    chk("inv_ovf", int'(cpu_if.ovf), 0);
    chk("inv_strobes", int'({update_op_I, update_op_II, update_op_IV}), 0);

    // write while busy
    done_cnt = 0;
    done_seq.delete();
    do_write(8'h43, 8'h11);
    do_write(8'h41, 8'h22);
`ifdef JTOPL_WRFIFO_EN
    do_write(8'h20, 8'h33);
    do_write(8'h80, 8'h44);
    step();
    chk("ovf_fifo_full", int'(cpu_if.ovf), 1);
    repeat (150) step();
    chk("fifo_done_cnt", done_cnt, 3);
    if (done_seq.size() == 3) begin
      chk("fifo_order0", int'(done_seq[0]), 8'h11);
      chk("fifo_order1", int'(done_seq[1]), 8'h22);
      chk("fifo_order2", int'(done_seq[2]), 8'h33);
    end
`else
    step();
    chk("ovf_dropped", int'(cpu_if.ovf), 1);
    repeat (60) step();
    chk("drop_done_cnt", done_cnt, 1);
    chk("drop_dout", int'(dout), 8'h11);
`endif

    // reset in the middle of WAIT
    wait_for(4, 5, "slot5_b");
    do_write(8'h60, 8'h1F);
    step();
    rst_n = 1'b0;
    step();
    chk("rstw_busy", int'(cpu_if.busy), 0);
    chk("rstw_slot", int'(slot), 0);
    chk("rstw_strobes", int'({update_op_I, update_op_II, update_op_IV, up_ar_dr}), 0);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (30) step();
    chk("rstw_no_done", done_cnt, 0);
    chk("rstw_ovf", int'(cpu_if.ovf), 0);

    // randomized traffic
    cen_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 99) < 5) begin
        ra = 8'($urandom_range(0, 255));
      end else begin
        ra = {3'($urandom_range(1, 4)), 2'($urandom_range(0, 2)), 3'($urandom_range(0, 5))};
      end
      cpu_if.wr   = ($urandom_range(0, 99) < 10);
      cpu_if.addr = ra;
      cpu_if.din  = 8'($urandom_range(0, 255));
      step();
    end
    cpu_if.wr = 1'b0;
    cen_mode = 0;
    repeat (100) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtopl_wrsched.md
Name: jtopl_wrsched

Overview:
- Write scheduler for the operator circular shift register.
- Accepts CPU writes to the per-operator register banks 0x20/0x40/0x60/0x80 and decodes the target slot (0-17).
- Waits until that slot reaches each required pipeline stage and raises the matching bank select plus update_op_I/II/IV strobes, so the register shifter captures the data on the right cen edge.
- Owns the master 18-slot counter used by the whole operator pipeline.

Parameters:
- SLOTS, 18, operator slots per circulation.
- OFFS_I, 0, slot lead for the stage-I capture point.
- OFFS_II, 1, slot lead for the stage-II capture point.
- OFFS_IV, 3, slot lead for the stage-IV capture point.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; slot advance and capture occur only when cen=1
- wr  in  1  write strobe, one clk
- addr  in  8  register address
- din  in  8  write data
- dout  out  8  latched data for the shifter
- busy  out  1  write pending
- done  out  1  one-clk pulse when the final strobe has been consumed
- ovf  out  1  sticky: a write was lost
- slot  out  5  current slot counter
- up_am_mul  out  1  bank 0x20 selected
- up_ksl_tl  out  1  bank 0x40 selected
- up_ar_dr  out  1  bank 0x60 selected
- up_sl_rr  out  1  bank 0x80 selected
- update_op_I  out  1  stage-I capture strobe
- update_op_II  out  1  stage-II capture strobe
- update_op_IV  out  1  stage-IV capture strobe

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low. On rst_n=0 all outputs go to 0, slot=0, FSM=IDLE, and any pending write is discarded, including mid-WAIT.
- Slot counter: increments on clk when cen=1 and wraps 17->0. It free-runs independently of the FSM.
- Address decode: valid when addr[7:5] is one of {1,2,3,4} and off=addr[4:0] satisfies off<=0x15 and off[2:0]<=5.
  - grp=off[4:3] and sub=off[2:0].
  - tgt = (sub<3) ? grp*3+sub : 9+grp*3+(sub-3).
  - Invalid addresses are ignored: no state change, no ovf.
- Stages required per bank:
  - 0x20 needs II and IV.
  - 0x40 needs II and IV.
  - 0x60 needs I.
  - 0x80 needs I.
- FSM:
  - IDLE: on wr with a valid address, latch dout<=din, tgt, and the bank; set need_I/II/IV; busy<=1; go to WAIT.
  - WAIT: update_op_x = need_x & (slot == (tgt+OFFS_x) mod 18), combinational from registers.
    - The bank select stays high throughout WAIT.
    - need_x clears on a clk edge with cen=1 while update_op_x=1. A strobe held with cen=0 is not consumed.
    - When all need bits are clear, go to DONE.
  - DONE: done=1 for one clk, busy<=0, bank select<=0, then IDLE.
- Latency: at most 2*18 cen edges from accept to done. A write is accepted in the same clk in which wr arrives in IDLE.
- A wr in DONE is treated as busy.
- wr while busy: write dropped, ovf<=1 (sticky until reset). Unless the FIFO feature is enabled.
- Mod-18 arithmetic: done on 5 bits with conditional subtract. Offsets must each be <18.

Optional Feature:
- Macro: JTOPL_WRFIFO_EN.
- Enabled:
  - A 2-entry FIFO of {tgt, bank, data} sits in front of the FSM.
  - A wr while busy is queued.
  - ovf is set only when wr arrives with the FIFO full.
  - IDLE pops the FIFO head before looking at a new wr.
  - busy stays high while the FIFO is non-empty.
  - Reset empties the FIFO.
- Disabled: no FIFO logic and behaviour as above.

Decomposition:
- Package jtopl_pkg:
  - bank encoding constants BANK_AM_MUL=0, BANK_KSL_TL=1, BANK_AR_DR=2, BANK_SL_RR=3;
  - SLOT_N=18;
  - the per-bank stage-need table;
  - mod-18 add function.
- Sub-module: jtopl_wrsched_dec, a combinational address decoder (addr -> valid, bank, tgt).
- The FIFO stays inline under the macro.

Test Plan:
- Reset mid-WAIT:
  - write 0x60/0x1F, then pull rst_n low before the strobe;
  - expect busy=0, all strobes 0, slot=0, and no done.
- Bank 0x40, OFFS_II=1, OFFS_IV=3, cen every clk:
  - write addr 0x43 data 0x2A (tgt=9);
  - expect update_op_II at slot 10 and update_op_IV at slot 12, up_ksl_tl high, dout=0x2A;
  - then a done pulse and busy=0.
- cen gating: with cen=1 every 4th clk, write 0x80/0x5C to slot 0:
  - expect update_op_I held across non-cen clks and consumed only on the cen edge at slot 0;
  - exactly one capture.
- Wraparound: write 0x35 (tgt=17) with OFFS_IV=3:
  - expect update_op_IV at slot 2 and update_op_II at slot 0.
- Invalid address 0x26 and 0xA0:
  - busy stays 0, no strobes, ovf stays 0.
- Write while busy:
  - without JTOPL_WRFIFO_EN, second write 0x41 dropped, ovf=1;
  - with the macro, both writes complete in order with two done pulses;
  - a third write while the FIFO is full sets ovf.
